// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: multi-cycle load-use stalls, EX redirect flush and
// whole-pipe freeze on data-memory backpressure. Optional perf counters: HAZARD_PERF_CNT_EN.
module hazard_ctrl_unit #(
  parameter int REG_AW         = 5,
  parameter int LOAD_USE_STALL = 1,
  parameter int CNT_W          = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] id_ex_rd,
  input  logic              id_ex_mem_read,
  input  logic [REG_AW-1:0] if_id_rs1,
  input  logic [REG_AW-1:0] if_id_rs2,
  input  logic              if_id_use_rs1,
  input  logic              if_id_use_rs2,
  input  logic              ex_redirect,
  input  logic              dmem_busy,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              id_ex_write,
  output logic              ex_mem_write,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic              stall_active,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_flush_cnt
);

  typedef enum logic [0:0] {IDLE, LU_STALL} state_t;

  localparam logic [CNT_W-1:0] STALL_INIT = CNT_W'(LOAD_USE_STALL - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hazard;

  assign hazard = id_ex_mem_read && (id_ex_rd != '0) &&
                  ((if_id_use_rs1 && (id_ex_rd == if_id_rs1)) ||
                   (if_id_use_rs2 && (id_ex_rd == if_id_rs2)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_write  = 1'b1;
    ex_mem_write = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    stall_active = rst_n && (state_q == LU_STALL);

    if (!rst_n) begin
      // outputs stay at their pass-through defaults while reset is held
    end else if (dmem_busy) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      ex_mem_write = 1'b0;
    end else if (ex_redirect) begin
      // the stalled ID instruction is on the wrong path, so any stall is abandoned
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      state_d     = IDLE;
      cnt_d       = '0;
    end else if (state_q == LU_STALL) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_flush = 1'b1;
      if (cnt_q == CNT_ONE) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q - CNT_ONE;
      end
    end else if (hazard) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_flush = 1'b1;
      if (LOAD_USE_STALL > 1) begin
        state_d = LU_STALL;
        cnt_d   = STALL_INIT;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_flush_q, perf_flush_d;

  // a load-use bubble is the only source of id_ex_flush without if_id_flush
  always_comb begin
    perf_stall_d = perf_stall_q;
    perf_flush_d = perf_flush_q;
    if (id_ex_flush && !if_id_flush) perf_stall_d = perf_stall_q + 32'd1;
    if (if_id_flush)                 perf_flush_d = perf_flush_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign perf_stall_cnt = perf_stall_q;
  assign perf_flush_cnt = perf_flush_q;
`else
  assign perf_stall_cnt = '0;
  assign perf_flush_cnt = '0;
`endif

endmodule
